// File: rtl/eight_bit_acc_pkg.sv
// Shared types and widths for the eight-bit accumulator.
package eight_bit_acc_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/eight_bit_adder.sv
// Plain 8-bit ripple adder with carry-in and carry-out.
module eight_bit_adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Carry
);

  assign {Carry, Sum} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};

endmodule

// File: rtl/eight_bit_accumulator.sv
// Sums N_OPS streamed operands and presents the total with carry statistics.
// Optional macro SATURATE_EN: a carry-out pins the accumulator at 8'hFF instead of wrapping.
module eight_bit_accumulator
  import eight_bit_acc_pkg::*;
#(
  parameter int N_OPS = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Sum,
  output logic              Carry,
  output logic [CNT_W-1:0]  carry_count
);

  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(N_OPS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic              carry_q, carry_nxt;
  logic [CNT_W-1:0]  cc, cc_nxt;
  logic [CNT_W-1:0]  op_cnt, op_cnt_nxt;
  logic [DATA_W-1:0] add_a, add_sum;
  logic              add_co;
  logic              xfer;

  assign in_ready    = (state != DONE);
  assign out_valid   = (state == DONE);
  assign xfer        = in_valid && in_ready;
  assign Sum         = acc;
  assign Carry       = carry_q;
  assign carry_count = cc;

  // The first operand of a run is added to zero, never to a stale total.
  assign add_a = (state == IDLE) ? '0 : acc;

  eight_bit_adder u_adder (
    .A     (add_a),
    .B     (A),
    .Cin   (1'b0),
    .Sum   (add_sum),
    .Carry (add_co)
  );

  always_comb begin
    // NOTE: every signal gets a hold value first so no path leaves it unassigned (no latches).
    state_nxt  = state;
    acc_nxt    = acc;
    carry_nxt  = carry_q;
    cc_nxt     = cc;
    op_cnt_nxt = op_cnt;

    if (clear) begin
      state_nxt  = IDLE;
      acc_nxt    = '0;
      carry_nxt  = 1'b0;
      cc_nxt     = '0;
      op_cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (xfer) begin
`ifdef SATURATE_EN
            acc_nxt = add_co ? '1 : add_sum;
`else
            acc_nxt = add_sum;
`endif
            if (add_co) begin
              carry_nxt = 1'b1;
              if (cc != CNT_MAX) cc_nxt = cc + 1'b1;
            end
            op_cnt_nxt = op_cnt + 1'b1;
            state_nxt  = (op_cnt_nxt == LAST_OP) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt  = IDLE;
            acc_nxt    = '0;
            carry_nxt  = 1'b0;
            cc_nxt     = '0;
            op_cnt_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      acc     <= '0;
      carry_q <= 1'b0;
      cc      <= '0;
      op_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      carry_q <= carry_nxt;
      cc      <= cc_nxt;
      op_cnt  <= op_cnt_nxt;
    end
  end

endmodule
